// File: rtl/issue_select_ctrl.sv
// Issue-queue controller: tracks operand readiness from writeback broadcasts and grants the oldest ready entry.
// Optional ISSUE_WAKEUP_BYPASS_EN lets a same-cycle broadcast make an entry eligible immediately.
module issue_select_ctrl #(
   parameter int DEPTH        = 16,
   parameter int OPCODE_WIDTH = 7,
   parameter int TAG_WIDTH    = 6,
   parameter int AGE_WIDTH    = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       disp_valid,
   output logic                       disp_ready,
   input  logic [OPCODE_WIDTH-1:0]    disp_op,
   input  logic [TAG_WIDTH-1:0]       disp_dst_tag,
   input  logic [TAG_WIDTH-1:0]       disp_src1_tag,
   input  logic [TAG_WIDTH-1:0]       disp_src2_tag,
   input  logic                       disp_src1_rdy,
   input  logic                       disp_src2_rdy,
   input  logic                       wb_valid,
   input  logic [TAG_WIDTH-1:0]       wb_tag,
   input  logic [OPCODE_WIDTH-1:0]    fu_op,
   output logic                       iss_valid,
   input  logic                       iss_ready,
   output logic [$clog2(DEPTH)-1:0]   iss_addr,
   output logic [OPCODE_WIDTH-1:0]    iss_op,
   output logic [TAG_WIDTH-1:0]       iss_dst_tag,
   output logic [AGE_WIDTH-1:0]       count,
   output logic                       full,
   output logic                       empty
);
   localparam int IDX_W = $clog2(DEPTH);

   logic [DEPTH-1:0]        valid_reg;
   logic [AGE_WIDTH-1:0]    count_reg;
   logic [OPCODE_WIDTH-1:0] op_reg       [DEPTH];
   logic [TAG_WIDTH-1:0]    dst_tag_reg  [DEPTH];
   logic [TAG_WIDTH-1:0]    src1_tag_reg [DEPTH];
   logic [TAG_WIDTH-1:0]    src2_tag_reg [DEPTH];
   logic [DEPTH-1:0]        src1_rdy_reg;
   logic [DEPTH-1:0]        src2_rdy_reg;
   logic [AGE_WIDTH-1:0]    age_reg      [DEPTH];

   logic [DEPTH-1:0]        wb_hit1, wb_hit2, eligible;
   logic                    sel_found;
   logic [IDX_W-1:0]        sel_idx;
   logic [AGE_WIDTH-1:0]    sel_age;
   logic [IDX_W-1:0]        free_idx;
   logic                    disp_fire, iss_fire;
   logic                    disp_src1_rdy_byp, disp_src2_rdy_byp;
   logic [AGE_WIDTH-1:0]    new_age, count_next;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         assign wb_hit1[gi] = wb_valid && (wb_tag == src1_tag_reg[gi]);
         assign wb_hit2[gi] = wb_valid && (wb_tag == src2_tag_reg[gi]);
`ifdef ISSUE_WAKEUP_BYPASS_EN
         assign eligible[gi] = valid_reg[gi] && (op_reg[gi] == fu_op)
                               && (src1_rdy_reg[gi] || wb_hit1[gi])
                               && (src2_rdy_reg[gi] || wb_hit2[gi]);
`else
         assign eligible[gi] = valid_reg[gi] && (op_reg[gi] == fu_op)
                               && src1_rdy_reg[gi] && src2_rdy_reg[gi];
`endif
      end
   endgenerate

   // Ages are unique, so a strict less-than scan finds the single oldest eligible entry.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_age   = '1;
      for (int i = 0; i < DEPTH; i++) begin
         if (eligible[i] && (!sel_found || (age_reg[i] < sel_age))) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
            sel_age   = age_reg[i];
         end
      end
   end

   always_comb begin
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_reg[i]) free_idx = IDX_W'(i);
      end
   end

   assign full        = (count_reg == AGE_WIDTH'(DEPTH));
   assign empty       = (count_reg == '0);
   assign disp_ready  = !full;
   assign count       = count_reg;
   assign iss_valid   = sel_found;
   assign iss_addr    = sel_found ? sel_idx : '0;
   assign iss_op      = sel_found ? op_reg[sel_idx] : '0;
   assign iss_dst_tag = sel_found ? dst_tag_reg[sel_idx] : '0;

   assign disp_fire         = disp_valid && disp_ready;
   assign iss_fire          = sel_found && iss_ready;
   assign disp_src1_rdy_byp = disp_src1_rdy || (wb_valid && (wb_tag == disp_src1_tag));
   assign disp_src2_rdy_byp = disp_src2_rdy || (wb_valid && (wb_tag == disp_src2_tag));
   assign new_age           = count_reg - AGE_WIDTH'(iss_fire);
   assign count_next        = count_reg + AGE_WIDTH'(disp_fire) - AGE_WIDTH'(iss_fire);

   // Only occupancy needs reset; payload is qualified by valid_reg everywhere it is read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= '0;
         count_reg <= '0;
      end else if (flush) begin
         valid_reg <= '0;
         count_reg <= '0;
      end else begin
         if (iss_fire)  valid_reg[sel_idx]  <= 1'b0;
         if (disp_fire) valid_reg[free_idx] <= 1'b1;
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (disp_fire && (free_idx == IDX_W'(i))) begin
            op_reg[i]       <= disp_op;
            dst_tag_reg[i]  <= disp_dst_tag;
            src1_tag_reg[i] <= disp_src1_tag;
            src2_tag_reg[i] <= disp_src2_tag;
            src1_rdy_reg[i] <= disp_src1_rdy_byp;
            src2_rdy_reg[i] <= disp_src2_rdy_byp;
            age_reg[i]      <= new_age;
         end else begin
            if (wb_hit1[i]) src1_rdy_reg[i] <= 1'b1;
            if (wb_hit2[i]) src2_rdy_reg[i] <= 1'b1;
            if (iss_fire && valid_reg[i] && (age_reg[i] > sel_age))
               age_reg[i] <= age_reg[i] - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_issue_select_ctrl.sv
// Scoreboard bench for issue_select_ctrl: an age-ordered queue model predicts every cycle's outputs;
// a negedge monitor pops and compares. Directed test-plan scenarios precede a randomized run.
module tb_issue_select_ctrl;
   localparam int DEPTH = 16;
`ifdef ISSUE_WAKEUP_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush, disp_valid, disp_ready;
   logic [6:0] disp_op, fu_op, iss_op;
   logic [5:0] disp_dst_tag, disp_src1_tag, disp_src2_tag, wb_tag, iss_dst_tag;
   logic       disp_src1_rdy, disp_src2_rdy, wb_valid, iss_valid, iss_ready;
   logic [3:0] iss_addr;
   logic [4:0] count;
   logic       full, empty;

   always #5 clk = ~clk;

   issue_select_ctrl dut (
      .clk(clk), .rst(rst), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
      .disp_dst_tag(disp_dst_tag), .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
      .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .fu_op(fu_op),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_addr(iss_addr),
      .iss_op(iss_op), .iss_dst_tag(iss_dst_tag),
      .count(count), .full(full), .empty(empty)
   );

   // Model: queue position is the age (index 0 = oldest); deleting an entry ages everything younger.
   typedef struct {
      int         slot;
      logic [6:0] op;
      logic [5:0] dst, t1, t2;
      bit         r1, r2;
   } ent_t;
   typedef struct packed {
      logic       v;
      logic [3:0] addr;
      logic [6:0] op;
      logic [5:0] dst;
      logic [4:0] cnt;
      logic       full, empty, drdy;
   } exp_t;

   ent_t mq[$];
   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   function automatic bit src_ok(bit r, logic [5:0] t);
      return r || (BYP && wb_valid && (wb_tag == t));
   endfunction

   function automatic int model_sel();
      for (int k = 0; k < mq.size(); k++)
         if (mq[k].op == fu_op && src_ok(mq[k].r1, mq[k].t1) && src_ok(mq[k].r2, mq[k].t2))
            return k;
      return -1;
   endfunction

   function automatic int free_slot();
      for (int s = 0; s < DEPTH; s++) begin
         bit used = 1'b0;
         foreach (mq[k]) if (mq[k].slot == s) used = 1'b1;
         if (!used) return s;
      end
      return -1;
   endfunction

   task automatic model_update();
      int   k = model_sel();
      int   ds = free_slot();
      bit   was_full = (mq.size() == DEPTH);
      ent_t n;
      if (flush) begin
         mq.delete();
      end else begin
         if (wb_valid)
            foreach (mq[j]) begin
               if (mq[j].t1 == wb_tag) mq[j].r1 = 1'b1;
               if (mq[j].t2 == wb_tag) mq[j].r2 = 1'b1;
            end
         if (iss_ready && k >= 0) mq.delete(k);
         if (disp_valid && !was_full) begin
            n.slot = ds; n.op = disp_op; n.dst = disp_dst_tag;
            n.t1 = disp_src1_tag; n.t2 = disp_src2_tag;
            n.r1 = disp_src1_rdy || (wb_valid && wb_tag == disp_src1_tag);
            n.r2 = disp_src2_rdy || (wb_valid && wb_tag == disp_src2_tag);
            mq.push_back(n);
         end
      end
   endtask

   // Called at posedge+1 with inputs already set: predict this cycle, then advance the model at the edge.
   task automatic step();
      exp_t e;
      int   k = model_sel();
      e.v     = (k >= 0);
      e.addr  = (k >= 0) ? 4'(mq[k].slot) : 4'd0;
      e.op    = (k >= 0) ? mq[k].op : 7'd0;
      e.dst   = (k >= 0) ? mq[k].dst : 6'd0;
      e.cnt   = 5'(mq.size());
      e.full  = (mq.size() == DEPTH);
      e.empty = (mq.size() == 0);
      e.drdy  = (mq.size() != DEPTH);
      sb.push_back(e);
      @(posedge clk);
      model_update();
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (iss_valid !== e.v || iss_addr !== e.addr || iss_op !== e.op || iss_dst_tag !== e.dst) begin
            failures++;
            $display("FAIL issue_grant t=%0t got v=%0d addr=%0d op=%0d dst=%0d want v=%0d addr=%0d op=%0d dst=%0d",
                     $time, iss_valid, iss_addr, iss_op, iss_dst_tag, e.v, e.addr, e.op, e.dst);
         end
         checks++;
         if (count !== e.cnt || full !== e.full || empty !== e.empty || disp_ready !== e.drdy) begin
            failures++;
            $display("FAIL status t=%0t got count=%0d full=%0d empty=%0d disp_ready=%0d want count=%0d full=%0d empty=%0d disp_ready=%0d",
                     $time, count, full, empty, disp_ready, e.cnt, e.full, e.empty, e.drdy);
         end
         if (iss_valid && iss_ready && !flush)
            $display("ISSUE t=%0t addr=%0d op=%0d dst=%0d count=%0d", $time, iss_addr, iss_op, iss_dst_tag, count);
      end
   end

   task automatic check_reset(string name);
      checks++;
      if (count !== 5'd0 || full !== 1'b0 || empty !== 1'b1 || disp_ready !== 1'b1 ||
          iss_valid !== 1'b0 || iss_addr !== 4'd0 || iss_op !== 7'd0 || iss_dst_tag !== 6'd0) begin
         failures++;
         $display("FAIL %s got count=%0d full=%0d empty=%0d drdy=%0d iv=%0d addr=%0d op=%0d dst=%0d want 0 0 1 1 0 0 0 0",
                  name, count, full, empty, disp_ready, iss_valid, iss_addr, iss_op, iss_dst_tag);
      end
   endtask

   task automatic clr();
      flush = 0; disp_valid = 0; disp_op = 0; disp_dst_tag = 0;
      disp_src1_tag = 0; disp_src2_tag = 0; disp_src1_rdy = 0; disp_src2_rdy = 0;
      wb_valid = 0; wb_tag = 0; fu_op = 0; iss_ready = 0;
   endtask

   task automatic dispatch(logic [6:0] op, logic [5:0] dst, logic [5:0] t1, bit r1, logic [5:0] t2, bit r2);
      disp_valid = 1; disp_op = op; disp_dst_tag = dst;
      disp_src1_tag = t1; disp_src1_rdy = r1; disp_src2_tag = t2; disp_src2_rdy = r2;
      step();
      disp_valid = 0;
   endtask

   task automatic do_flush();
      flush = 1; step(); flush = 0;
   endtask

   initial begin
      clr();
      repeat (2) @(posedge clk);
      #1;
      check_reset("reset_values");
      rst = 0;

      // Dispatch three ready R-type entries, then drain in age order.
      for (int i = 0; i < 3; i++) dispatch(7'd51, 6'(10 + i), 6'd0, 1, 6'd0, 1);
      fu_op = 7'd51; iss_ready = 1;
      repeat (4) step();
      iss_ready = 0;

      // Fill to 16, issue slot 5, refill slot 5 with a load; older load in slot 9 must win.
      for (int i = 0; i < DEPTH; i++)
         dispatch((i == 5) ? 7'd19 : ((i == 9) ? 7'd3 : 7'd51), 6'(i + 32), 6'd0, 1, 6'd0, 1);
      fu_op = 7'd19; iss_ready = 1; step(); iss_ready = 0;
      dispatch(7'd3, 6'd55, 6'd0, 1, 6'd0, 1);
      fu_op = 7'd3; iss_ready = 1; step(); step(); iss_ready = 0;
      do_flush();

      // Wakeup via registered broadcast (bypass build sees it the same cycle).
      fu_op = 7'd19;
      dispatch(7'd19, 6'd20, 6'd12, 0, 6'd0, 1);
      step();
      wb_valid = 1; wb_tag = 6'd12; step(); wb_valid = 0;
      step();

      // Dispatch-time bypass on src2.
      do_flush();
      wb_valid = 1; wb_tag = 6'd7;
      dispatch(7'd19, 6'd21, 6'd0, 1, 6'd7, 0);
      wb_valid = 0;
      step();

      // Dispatch refused at full while an issue fires; then drain to see ages 0..14.
      do_flush();
      for (int i = 0; i < DEPTH; i++) dispatch(7'd51, 6'(i), 6'd0, 1, 6'd0, 1);
      fu_op = 7'd51; iss_ready = 1;
      dispatch(7'd51, 6'd63, 6'd0, 1, 6'd0, 1);
      repeat (16) step();
      iss_ready = 0;

      // Flush dominates a same-cycle dispatch.
      for (int i = 0; i < 6; i++) dispatch(7'd51, 6'(i), 6'd0, 1, 6'd0, 1);
      flush = 1; disp_valid = 1; disp_src1_rdy = 1; disp_src2_rdy = 1; iss_ready = 1;
      step();
      clr(); fu_op = 7'd51;
      step();

      // Randomized traffic.
      for (int c = 0; c < 1500; c++) begin
         logic [6:0] ops [3];
         ops[0] = 7'd51; ops[1] = 7'd3; ops[2] = 7'd19;
         flush         = ($urandom_range(0, 99) < 2);
         disp_valid    = ($urandom_range(0, 99) < 60);
         disp_op       = ops[$urandom_range(0, 2)];
         disp_dst_tag  = 6'($urandom_range(0, 63));
         disp_src1_tag = 6'($urandom_range(0, 7));
         disp_src2_tag = 6'($urandom_range(0, 7));
         disp_src1_rdy = ($urandom_range(0, 1) == 1);
         disp_src2_rdy = ($urandom_range(0, 1) == 1);
         wb_valid      = ($urandom_range(0, 1) == 1);
         wb_tag        = 6'($urandom_range(0, 7));
         fu_op         = ops[$urandom_range(0, 2)];
         iss_ready     = ($urandom_range(0, 99) < 45);
         step();

         // Asynchronous reset mid-cycle, away from the monitor's sample point.
         if (c == 700) begin
            clr();
            @(negedge clk);
            #1 rst = 1;
            #1 check_reset("async_reset");
            #1 rst = 0;
            mq.delete();
            @(posedge clk);
            #1;
         end
      end

      clr();
      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/issue_select_ctrl.md
# issue_select_ctrl

Issue-queue controller for the RV64 out-of-order backend. It holds up to DEPTH dispatched instructions and tracks their source-operand readiness from writeback tag broadcasts. Each cycle it grants the oldest ready entry whose opcode matches the requesting functional unit, using a valid/ready handshake. Age is maintained internally as a dense ordering: age 0 is the oldest entry, and ages are never duplicated.

## Interface
Parameters:
- DEPTH, 16, number of queue entries (power of two)
- OPCODE_WIDTH, 7, RV64 opcode field width
- TAG_WIDTH, 6, physical register tag width
- AGE_WIDTH, 5, age field width, ≥ $clog2(DEPTH)+1

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  invalidate all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept an entry (= !full)
- disp_op  in  OPCODE_WIDTH  opcode of the dispatched instruction
- disp_dst_tag  in  TAG_WIDTH  destination tag
- disp_src1_tag / disp_src2_tag  in  TAG_WIDTH  source tags
- disp_src1_rdy / disp_src2_rdy  in  1  source already available
- wb_valid  in  1  writeback broadcast valid
- wb_tag  in  TAG_WIDTH  broadcast tag
- fu_op  in  OPCODE_WIDTH  opcode class the functional unit accepts this cycle
- iss_valid  out  1  a grantable entry exists
- iss_ready  in  1  functional unit accepts
- iss_addr  out  $clog2(DEPTH)  granted entry index
- iss_op  out  OPCODE_WIDTH  granted opcode
- iss_dst_tag  out  TAG_WIDTH  granted destination tag
- count  out  AGE_WIDTH  number of valid entries
- full / empty  out  1  count==DEPTH / count==0

## Operation
- Per-entry state: valid, op, dst_tag, src tags, src ready bits, age.
- **Dispatch fire** = disp_valid && disp_ready.
  - The entry is written at the lowest-index invalid slot.
  - Each src ready bit = disp_srcN_rdy || (wb_valid && wb_tag==disp_srcN_tag).
- **Wakeup**: every valid entry with a pending source whose tag equals wb_tag (when wb_valid) sets that ready bit at the edge.
- **Eligible entry**: valid && op==fu_op && src1 ready && src2 ready.
  - Select = the eligible entry with the smallest age.
  - Ages are unique, so no tie-break is needed.
- iss_valid = any entry eligible. iss_addr, iss_op and iss_dst_tag are the selected entry's fields; all three are 0 when iss_valid=0. All issue outputs are combinational from registered state and fu_op.
- **Issue fire** = iss_valid && iss_ready. On fire:
  - the granted entry is invalidated at the edge;
  - every valid entry with age > the granted age decrements by 1.
- **New entry age** = count − (issue fire ? 1 : 0). This keeps ages dense in 0..count−1.
- count updates by +dispatch fire − issue fire. Simultaneous dispatch and issue leaves count unchanged.
- disp_ready does not anticipate a same-cycle issue: when full, dispatch stalls even if an issue fires.
- **Flush**: all valid bits clear and count=0 at the edge. Flush dominates any same-cycle dispatch, issue, or wakeup.
- A wakeup in the same cycle that a dispatch writes a slot is applied through the dispatch bypass above. No update is lost.

## Timing
- Reset values: all entries invalid; count=0; full=0; empty=1; disp_ready=1; iss_valid=0; iss_addr=0; iss_op=0; iss_dst_tag=0.
- Reset asserted mid-operation clears all state immediately (asynchronous), regardless of clk.
- Dispatch → earliest issue: 1 cycle. An entry written at edge N is selectable in cycle N+1 if ready.
- Wakeup → eligibility: 1 cycle (registered), unless the bypass macro below is enabled.
- Issue: the grant is visible in the same cycle as fu_op. The entry is freed at the edge on which iss_ready=1.
- The requester may change fu_op at any time; iss_* follows combinationally.
- If iss_valid=1 and iss_ready=0, the grant is held as long as state and fu_op are unchanged.

## Configuration
- Macro: `ISSUE_WAKEUP_BYPASS_EN`.
- **Defined**: eligibility also treats a pending source as ready when wb_valid && wb_tag matches it in the current cycle. Wakeup → issue takes 0 cycles (back-to-back dependent issue).
- **Undefined**: readiness comes only from registered ready bits. Wakeup → issue takes 1 cycle.

## Test plan
- **Dispatch and age order**: dispatch 3 ready R_type (op=51) entries, then set fu_op=51, iss_ready=1.
  - Required: iss_addr is 0, then 1, then 2 on consecutive cycles; count goes 3→0; empty=1 afterwards.
- **Oldest-first after holes**: fill 16 entries (full=1, disp_ready=0); issue entry 5, then dispatch a new load (op=3) entry.
  - Required: the new entry goes to slot 5 with age 15.
  - Required: a ready older load in slot 9 wins over slot 5.
- **Wakeup**: dispatch op=19 with src1_tag=12 not ready.
  - Required: iss_valid=0.
  - Then wb_valid=1, wb_tag=12. Required: iss_valid=1 one cycle later without the macro, and in the same cycle with the macro.
- **Dispatch-time bypass**: dispatch with src2_tag=7 not ready while wb_tag=7 is valid.
  - Required: the entry is issueable next cycle.
- **Simultaneous dispatch + issue at full**: with full=1 and iss_ready=1, assert disp_valid.
  - Required: dispatch is refused (disp_ready=0); count becomes 15; ages remain 0..14.
- **Flush and reset**: with 6 entries valid, assert flush together with disp_valid=1.
  - Required: count=0 and iss_valid=0 next cycle.
  - Asserting rst mid-cycle clears all outputs to their reset values immediately.
